// File: rtl/mux_2x1_arbiter_pkg.sv
// rtl/mux_2x1_arbiter_pkg.sv - shared types and constants for the 2:1 mux arbiter
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int HOLD_W = 8;

endpackage

// File: rtl/mux_2x1_arbiter_if.sv
// rtl/mux_2x1_arbiter_if.sv - requester/downstream bundle of the 2:1 mux arbiter
interface mux_2x1_arbiter_if #(
   parameter int WIDTH = 1
) ();

   logic             req_a;
   logic [WIDTH-1:0] a;
   logic             req_b;
   logic [WIDTH-1:0] b;
   logic             out_ready;
   logic             gnt_a;
   logic             gnt_b;
   logic             select;
   logic [WIDTH-1:0] out;
   logic             out_valid;

   modport master (
      output req_a, a, req_b, b, out_ready,
      input  gnt_a, gnt_b, select, out, out_valid
   );

   modport slave (
      input  req_a, a, req_b, b, out_ready,
      output gnt_a, gnt_b, select, out, out_valid
   );

endinterface

// File: rtl/mux_2x1_bus.sv
// rtl/mux_2x1_bus.sv - WIDTH-wide combinational 2:1 data mux
module mux_2x1_bus #(
   parameter int WIDTH = 1
) (
   input  logic             select,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out
);

   assign out = select ? b : a;

endmodule

// File: rtl/mux_2x1_arbiter.sv
// rtl/mux_2x1_arbiter.sv - round-robin owner of a shared 2:1 mux select
// Optional per-grant beat cap compiled in with MUX_ARB_HOLD_LIMIT_EN.
module mux_2x1_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mux_2x1_arbiter_if.slave   bus
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("MAX_HOLD must be within 1..255");
   end

   state_t state, state_nxt;
   logic   last_b, last_b_nxt;
   logic   select_q, select_nxt;
   logic   hold_hit;

   assign bus.gnt_a     = (state == GNT_A);
   assign bus.gnt_b     = (state == GNT_B);
   assign bus.select    = select_q;
   assign bus.out_valid = (bus.gnt_a & bus.req_a) | (bus.gnt_b & bus.req_b);

`ifdef MUX_ARB_HOLD_LIMIT_EN
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              beat;

   assign beat     = bus.out_valid & bus.out_ready;
   assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD));

   // A grant change or a limit hit with nobody waiting starts a fresh window.
   always_comb begin
      hold_cnt_nxt = hold_cnt;
      if (state == IDLE || state_nxt != state || hold_hit) begin
         hold_cnt_nxt = '0;
      end else if (beat) begin
         hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
      end
   end
`else
   assign hold_hit = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      last_b_nxt = last_b;
      select_nxt = select_q;
      case (state)
         IDLE: begin
            if (bus.req_a && bus.req_b) begin
               state_nxt = last_b ? GNT_A : GNT_B;
            end else if (bus.req_a) begin
               state_nxt = GNT_A;
            end else if (bus.req_b) begin
               state_nxt = GNT_B;
            end
         end
         GNT_A: begin
            if (!bus.req_a || (hold_hit && bus.req_b)) begin
               state_nxt = bus.req_b ? GNT_B : IDLE;
            end
         end
         GNT_B: begin
            if (!bus.req_b || (hold_hit && bus.req_a)) begin
               state_nxt = bus.req_a ? GNT_A : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Select and round-robin history only move when a grant is issued.
      if (state_nxt == GNT_A) begin
         last_b_nxt = 1'b0;
         select_nxt = SEL_A;
      end else if (state_nxt == GNT_B) begin
         last_b_nxt = 1'b1;
         select_nxt = SEL_B;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         select_q <= SEL_A;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         select_q <= select_nxt;
      end
   end

   mux_2x1_bus #(
      .WIDTH (WIDTH)
   ) u_bus (
      .select (select_q),
      .a      (bus.a),
      .b      (bus.b),
      .out    (bus.out)
   );

endmodule
